// File: rtl/ram32_byte_bridge.sv
// Byte-serial valid/ready front end driving a single 32x32 RAM macro port.
// Define RAM32_BRIDGE_BYTE_MASK_EN to append a byte-lane mask byte to writes.
module ram32_byte_bridge #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          wr_done,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WMASK,
    S_MEM,
    S_CAPT,
    S_RDATA
  } state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [1:0]    cnt_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] shift_q;
  logic          ram_en_q;
  logic [3:0]    ram_we_q;
  logic          wr_done_q;

  logic in_fire;
  logic out_fire;
  logic unused_cmd;

  assign in_ready  = (state_q == S_IDLE)
                   | (state_q == S_WDATA)
                   | (state_q == S_WMASK);
  assign out_valid = (state_q == S_RDATA);
  assign busy      = (state_q != S_IDLE);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = shift_q[7:0];
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign wr_done   = wr_done_q;
  assign ram_addr  = addr_q;
  assign ram_di    = wdata_q;

  // command bits [6:5] carry no meaning
  assign unused_cmd = ^in_data[6:5];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      cnt_q     <= 2'd0;
      wdata_q   <= '0;
      shift_q   <= '0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= 4'h0;
      wr_done_q <= 1'b0;
    end else begin
      ram_en_q  <= 1'b0;
      ram_we_q  <= 4'h0;
      wr_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            addr_q <= in_data[AW-1:0];
            rw_q   <= in_data[7];
            cnt_q  <= 2'd0;
            if (in_data[7]) begin
              state_q <= S_WDATA;
            end else begin
              state_q  <= S_MEM;
              ram_en_q <= 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (in_fire) begin
            wdata_q[{cnt_q, 3'b000} +: 8] <= in_data;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
`ifdef RAM32_BRIDGE_BYTE_MASK_EN
              state_q <= S_WMASK;
`else
              state_q   <= S_MEM;
              ram_en_q  <= 1'b1;
              ram_we_q  <= 4'hF;
              wr_done_q <= 1'b1;
`endif
            end
          end
        end
        S_WMASK: begin
          if (in_fire) begin
            state_q   <= S_MEM;
            ram_en_q  <= 1'b1;
            ram_we_q  <= in_data[3:0];
            wr_done_q <= 1'b1;
          end
        end
        S_MEM: begin
          state_q <= rw_q ? S_IDLE : S_CAPT;
        end
        S_CAPT: begin
          shift_q <= ram_do;
          cnt_q   <= 2'd0;
          state_q <= S_RDATA;
        end
        S_RDATA: begin
          if (out_fire) begin
            shift_q <= {8'h00, shift_q[DW-1:8]};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32_byte_bridge.sv
// Scoreboard bench for ram32_byte_bridge with a registered-output RAM model.
// Expected read bytes are queued at command time and popped on delivery.
module tb_ram32_byte_bridge;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        wr_done;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  logic [31:0] ram   [32] = '{default: '0};
  logic [31:0] model [32] = '{default: '0};
  logic [7:0]  exp_q [$];

  int checks = 0;
  int passed = 0;

`ifdef RAM32_BRIDGE_BYTE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  ram32_byte_bridge dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .wr_done(wr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram[ram_addr][i*8 +: 8] <= ram_di[i*8 +: 8];
      ram_do <= ram[ram_addr];
    end else begin
      ram_do <= '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 50)
      $display("FAIL send_timeout byte=%h in_ready=%b required 1",
               b, in_ready);
    else passed++;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wr_word(input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] m,
                         output logic en, output logic [3:0] we,
                         output logic [4:0] ad, output logic [31:0] di,
                         output logic wd, output logic en_next);
    logic [3:0] eff;
    send({3'b100, a});
    for (int i = 0; i < 4; i++) send(d[i*8 +: 8]);
    if (MASK_EN) send({4'h0, m});
    en = ram_en; we = ram_we; ad = ram_addr;
    di = ram_di; wd = wr_done;
    @(negedge CLK);
    en_next = ram_en | wr_done;
    eff = MASK_EN ? m : 4'hF;
    for (int i = 0; i < 4; i++)
      if (eff[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic rd_word(input logic [4:0] a, input int stall,
                         output logic en, output logic [3:0] we,
                         output int lat, output logic [31:0] got,
                         output bit stable, output bit busy_ok,
                         output logic tail_valid);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) exp_q.push_back(model[a][i*8 +: 8]);
    send({3'b000, a});
    en = ram_en; we = ram_we;
    lat = 0; stable = 1'b1; busy_ok = 1'b1; got = '0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    for (int k = 0; k < 4; k++) begin
      b = out_data;
      if (!out_valid) stable = 1'b0;
      if (!busy) busy_ok = 1'b0;
      repeat (stall) begin
        @(negedge CLK);
        if (!out_valid || out_data !== b) stable = 1'b0;
        if (!busy) busy_ok = 1'b0;
      end
      got[k*8 +: 8] = out_data;
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
    end
    tail_valid = out_valid;
  endtask

  task automatic test_reset();
    logic en, tv; logic [3:0] we; int lat;
    logic [31:0] got; bit st, bo; logic [7:0] e;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ram_en, ram_we, out_valid, out_data, busy, wr_done, in_ready}
        !== 17'b0_0000_0_00000000_0_0_1)
      $display("FAIL reset_outputs got en=%b we=%h ov=%b od=%h bz=%b wd=%b ir=%b",
               ram_en, ram_we, out_valid, out_data, busy, wr_done, in_ready);
    else passed++;
    RST_N = 1'b1;
    @(negedge CLK);
    send(8'h85); send(8'hEF); send(8'hBE);
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_write_busy got %b want 1", busy);
    else passed++;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({ram_en, out_valid, busy, wr_done} !== 4'b0000)
      $display("FAIL reset_mid_write en=%b ov=%b bz=%b wd=%b want 0000",
               ram_en, out_valid, busy, wr_done);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10)
      $display("FAIL after_reset ir=%b bz=%b want ir=1 bz=0", in_ready, busy);
    else passed++;
    @(negedge CLK);
    rd_word(5'd5, 0, en, we, lat, got, st, bo, tv);
    checks++;
    if ({en, we} !== 5'b1_0000)
      $display("FAIL post_reset_cmd en=%b we=%h want read access", en, we);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[k*8 +: 8] !== e)
        $display("FAIL post_reset_byte%0d got %h want %h", k, got[k*8 +: 8], e);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    logic en, wd, en2, tv; logic [3:0] we; logic [4:0] ad;
    logic [31:0] di, got; int lat; bit st, bo; logic [7:0] e;
    wr_word(5'd5, 32'hDEADBEEF, 4'hF, en, we, ad, di, wd, en2);
    checks++;
    if ({en, we, ad, wd} !== {1'b1, 4'hF, 5'd5, 1'b1})
      $display("FAIL wr_ctrl en=%b we=%h ad=%0d wd=%b want 1 F 5 1",
               en, we, ad, wd);
    else passed++;
    checks++;
    if (di !== 32'hDEADBEEF) $display("FAIL wr_di got %h want DEADBEEF", di);
    else passed++;
    checks++;
    if (en2 !== 1'b0) $display("FAIL wr_one_cycle en/wd still %b want 0", en2);
    else passed++;
    rd_word(5'd5, 0, en, we, lat, got, st, bo, tv);
    checks++;
    if ({en, we} !== 5'b1_0000)
      $display("FAIL rd_ctrl en=%b we=%h want 1 0", en, we);
    else passed++;
    checks++;
    if (lat !== 2) $display("FAIL rd_latency got %0d want 2", lat);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[k*8 +: 8] !== e)
        $display("FAIL rd_byte%0d got %h want %h", k, got[k*8 +: 8], e);
      else passed++;
    end
    checks++;
    if (got !== 32'hDEADBEEF) $display("FAIL rd_word got %h want DEADBEEF", got);
    else passed++;
    checks++;
    if ({tv, busy} !== 2'b00)
      $display("FAIL rd_tail ov=%b bz=%b want 0 0", tv, busy);
    else passed++;
  endtask

  task automatic test_stall();
    logic en, tv; logic [3:0] we; int lat;
    logic [31:0] got; bit st, bo; logic [7:0] e;
    rd_word(5'd5, 5, en, we, lat, got, st, bo, tv);
    checks++;
    if (st !== 1'b1) $display("FAIL stall_stable got %b want 1", st);
    else passed++;
    checks++;
    if (bo !== 1'b1) $display("FAIL stall_busy got %b want 1", bo);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[k*8 +: 8] !== e)
        $display("FAIL stall_byte%0d got %h want %h", k, got[k*8 +: 8], e);
      else passed++;
    end
    checks++;
    if ({tv, busy} !== 2'b00)
      $display("FAIL stall_extra_byte ov=%b bz=%b want 0 0", tv, busy);
    else passed++;
  endtask

  task automatic test_boundary();
    logic en, wd, en2, tv; logic [3:0] we; logic [4:0] ad;
    logic [31:0] di, g0, g31; int lat; bit st, bo; logic [7:0] e;
    wr_word(5'd0, 32'h00000000, 4'hF, en, we, ad, di, wd, en2);
    checks++;
    if (ad !== 5'd0) $display("FAIL addr0_wr got %0d want 0", ad);
    else passed++;
    wr_word(5'd31, 32'hFFFFFFFF, 4'hF, en, we, ad, di, wd, en2);
    checks++;
    if (ad !== 5'd31) $display("FAIL addr31_wr got %0d want 31", ad);
    else passed++;
    rd_word(5'd0, 0, en, we, lat, g0, st, bo, tv);
    rd_word(5'd31, 1, en, we, lat, g31, st, bo, tv);
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ((k < 4 ? g0[k*8 +: 8] : g31[(k-4)*8 +: 8]) !== e)
        $display("FAIL boundary_byte%0d got %h/%h want %h", k, g0, g31, e);
      else passed++;
    end
    checks++;
    if ({g0, g31} !== {32'h00000000, 32'hFFFFFFFF})
      $display("FAIL alias got a0=%h a31=%h want 0/FFFFFFFF", g0, g31);
    else passed++;
  endtask

  task automatic test_mask();
    logic en, wd, en2, tv; logic [3:0] we; logic [4:0] ad;
    logic [31:0] di, got; int lat; bit st, bo; logic [7:0] e;
    wr_word(5'd3, 32'hAAAAAAAA, 4'hF, en, we, ad, di, wd, en2);
    wr_word(5'd3, 32'h44332211, 4'h5, en, we, ad, di, wd, en2);
    checks++;
    if (we !== (MASK_EN ? 4'b0101 : 4'hF))
      $display("FAIL mask_we got %b want %b", we, MASK_EN ? 4'b0101 : 4'hF);
    else passed++;
    checks++;
    if ({en, wd} !== 2'b11) $display("FAIL mask_en_wd got %b want 11", {en, wd});
    else passed++;
    rd_word(5'd3, 0, en, we, lat, got, st, bo, tv);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[k*8 +: 8] !== e)
        $display("FAIL mask_byte%0d got %h want %h", k, got[k*8 +: 8], e);
      else passed++;
    end
    checks++;
    if (got !== (MASK_EN ? 32'hAA33AA11 : 32'h44332211))
      $display("FAIL mask_word got %h want %h", got,
               MASK_EN ? 32'hAA33AA11 : 32'h44332211);
    else passed++;
  endtask

  task automatic test_in_valid_hold();
    logic en, tv; logic [3:0] we; int lat, n, cyc;
    logic [31:0] got; bit st, bo, leak; logic [7:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back(model[5][i*8 +: 8]);
    in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1;
    @(negedge CLK);
    in_data = 8'h85;
    n = 0; cyc = 0; leak = 1'b0; got = '0;
    while (n < 4 && cyc < 20) begin
      if (in_ready) leak = 1'b1;
      if (out_valid) begin
        got[n*8 +: 8] = out_data;
        n++;
      end
      @(negedge CLK);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if ({leak, n} !== {1'b0, 32'd4})
      $display("FAIL hold_consume leak=%b bytes=%0d want 0 4", leak, n);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[k*8 +: 8] !== e)
        $display("FAIL hold_byte%0d got %h want %h", k, got[k*8 +: 8], e);
      else passed++;
    end
    checks++;
    if ({in_ready, busy} !== 2'b10)
      $display("FAIL hold_idle ir=%b bz=%b want 1 0", in_ready, busy);
    else passed++;
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy} !== 2'b11)
      $display("FAIL hold_cmd_taken ir=%b bz=%b want 1 1", in_ready, busy);
    else passed++;
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    if (MASK_EN) send(8'h0F);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_di} !== {1'b1, 4'hF, 5'd5, 32'h12345678})
      $display("FAIL hold_write en=%b we=%h ad=%0d di=%h want 1 F 5 12345678",
               ram_en, ram_we, ram_addr, ram_di);
    else passed++;
    model[5] = 32'h12345678;
    @(negedge CLK);
    rd_word(5'd5, 0, en, we, lat, got, st, bo, tv);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[k*8 +: 8] !== e)
        $display("FAIL hold_rb_byte%0d got %h want %h", k, got[k*8 +: 8], e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_boundary();
    test_mask();
    test_in_valid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
